anti_theft_fsm: RTL

- Sequences the car anti-theft system: arming, entry-delay countdown, siren and disarm.
- Consumes the four programmable delays (T_ARM_DELAY, T_DRIVER_DELAY, T_PASSENGER_DELAY, T_ALARM_DELAY) from the time-parameter block.
- Owns the single shared countdown timer and selects which delay is loaded into it.
- Sits between the debounced car inputs and the siren, status LED and hex display.

---
 rtl/anti_theft_pkg.sv | 17 +
 rtl/anti_theft_fsm_countdown_timer.sv | 56 +++++
 rtl/anti_theft_fsm.sv | 123 ++++++++++++
 3 files changed

// File: rtl/anti_theft_pkg.sv
// Shared types for the anti-theft sequencer: delay width and the state codes
// that also appear on the debug/display output.
package anti_theft_pkg;

  localparam int unsigned TW = 4;

  typedef enum logic [2:0] {
    ST_ARMED           = 3'd0,
    ST_TRIGGERED       = 3'd1,
    ST_SOUND_ALARM     = 3'd2,
    ST_DISARMED        = 3'd3,
    ST_WAIT_DOOR_OPEN  = 3'd4,
    ST_WAIT_DOOR_CLOSE = 3'd5,
    ST_ARM_DELAY       = 3'd6
  } state_e;

endpackage

// File: rtl/anti_theft_fsm_countdown_timer.sv
// Shared one-second countdown: load on start, decrement on each tick while
// running, and pulse expired for one cycle once the count has reached zero.
module countdown_timer #(
  parameter int unsigned W = anti_theft_pkg::TW
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         one_hz_enable,
  input  logic         start,
  input  logic         stop,
  input  logic [W-1:0] value,
  output logic [W-1:0] count,
  output logic         expired
);

  logic [W-1:0] count_q, count_d;
  logic         running_q, running_d;
  logic         expired_q, expired_d;

  // start outranks stop, ticks and a pending expiry, so a reload discards them
  always_comb begin
    count_d   = count_q;
    running_d = running_q;
    expired_d = 1'b0;
    if (start) begin
      count_d   = value;
      running_d = 1'b1;
    end else if (stop) begin
      count_d   = '0;
      running_d = 1'b0;
    end else if (running_q) begin
      if (count_q == '0) begin
        expired_d = 1'b1;
        running_d = 1'b0;
      end else if (one_hz_enable) begin
        count_d = count_q - W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      running_q <= running_d;
      expired_q <= expired_d;
    end
  end

  assign count   = count_q;
  assign expired = expired_q;

endmodule

// File: rtl/anti_theft_fsm.sv
// Car anti-theft sequencer: arming, entry delay, siren and disarm, driving
// the single shared countdown timer through its delay-select mux.
module anti_theft_fsm #(
  parameter int unsigned TW = anti_theft_pkg::TW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          one_hz_enable,
  input  logic          ignition,
  input  logic          driver_door,
  input  logic          passenger_door,
  input  logic          reprogram,
  input  logic [TW-1:0] t_arm,
  input  logic [TW-1:0] t_driver,
  input  logic [TW-1:0] t_passenger,
  input  logic [TW-1:0] t_alarm,
  output logic          siren,
  output logic          status_indicator,
  output logic [2:0]    state,
  output logic [TW-1:0] time_remaining
);
  import anti_theft_pkg::*;

  state_e        state_q, state_d;
  logic          siren_q, siren_d;
  logic          status_q, status_d;
  logic          tmr_start, tmr_stop, tmr_expired;
  logic [TW-1:0] tmr_value, tmr_count;
  logic          any_door;

  assign any_door = driver_door | passenger_door;

  always_comb begin
    state_d   = state_q;
    tmr_start = 1'b0;
    tmr_stop  = 1'b0;
    tmr_value = t_driver;
    if (reprogram) begin
      state_d  = ST_ARMED;
      tmr_stop = 1'b1;
    end else begin
      case (state_q)
        ST_ARMED:
          if (ignition) state_d = ST_DISARMED;
          else if (driver_door) begin
            state_d   = ST_TRIGGERED;
            tmr_start = 1'b1;
            tmr_value = t_driver;
          end else if (passenger_door) begin
            state_d   = ST_TRIGGERED;
            tmr_start = 1'b1;
            tmr_value = t_passenger;
          end
        ST_TRIGGERED:
          if (ignition) state_d = ST_DISARMED;
          else if (tmr_expired) state_d = ST_SOUND_ALARM;
        ST_SOUND_ALARM:
          if (ignition) state_d = ST_DISARMED;
          else if (any_door) begin
            tmr_start = 1'b1;
            tmr_value = t_alarm;
          end else if (tmr_expired) state_d = ST_ARMED;
        ST_DISARMED:
          if (!ignition) state_d = ST_WAIT_DOOR_OPEN;
        ST_WAIT_DOOR_OPEN:
          if (ignition) state_d = ST_DISARMED;
          else if (driver_door) state_d = ST_WAIT_DOOR_CLOSE;
        ST_WAIT_DOOR_CLOSE:
          if (ignition) state_d = ST_DISARMED;
          else if (!any_door) begin
            state_d   = ST_ARM_DELAY;
            tmr_start = 1'b1;
            tmr_value = t_arm;
          end
        ST_ARM_DELAY:
          if (ignition) state_d = ST_DISARMED;
          else if (any_door) begin
            state_d  = ST_WAIT_DOOR_CLOSE;
            tmr_stop = 1'b1;
          end else if (tmr_expired) state_d = ST_ARMED;
        default: state_d = ST_ARMED;
      endcase
    end

    siren_d = (state_d == ST_SOUND_ALARM);
    // LED blinks only while staying in ARMED; any (re-)entry starts it dark
    case (state_d)
      ST_TRIGGERED, ST_SOUND_ALARM: status_d = 1'b1;
      ST_ARMED: status_d = (state_q == ST_ARMED && !reprogram) ?
                           (status_q ^ one_hz_enable) : 1'b0;
      default: status_d = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_ARMED;
      siren_q  <= 1'b0;
      status_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      siren_q  <= siren_d;
      status_q <= status_d;
    end
  end

  countdown_timer #(.W(TW)) u_timer (
    .clock        (clock),
    .reset        (reset),
    .one_hz_enable(one_hz_enable),
    .start        (tmr_start),
    .stop         (tmr_stop),
    .value        (tmr_value),
    .count        (tmr_count),
    .expired      (tmr_expired)
  );

  assign siren            = siren_q;
  assign status_indicator = status_q;
  assign state            = state_q;
  assign time_remaining   = tmr_count;

endmodule
